// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the performance counter bank.
//   - Channel indices as seen on rd_sel / ovf / cnt_bus in the default
//     configuration (cycle counter, retired instructions, cache hits).
//   - Overflow mode encodings for the SAT parameter.
//   - Read source encoding for rd_src.
// -----------------------------------------------------------------------------
package perf_pkg;

    // Channel indices (index 0 is always the free-running cycle counter)
    localparam int CH_CYCLE = 0;
    localparam int CH_INST  = 1;
    localparam int CH_HIT   = 2;

    // Overflow behaviour selected by the SAT parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Read port source select
    typedef enum logic {
        SRC_LIVE = 1'b0,
        SRC_SNAP = 1'b1
    } rd_src_e;

endpackage : perf_pkg

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// One W-bit event counter with a sticky overflow flag.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (clears cnt and ovf)
//   inc  in   count this cycle (already qualified by the global enable)
//   clr  in   synchronous clear of cnt and ovf; wins over inc
//   cnt  out  W-bit counter register
//   ovf  out  sticky overflow flag, set by any increment attempted at all-ones
//
// Parameters:
//   W    counter width
//   SAT  MODE_WRAP: all-ones + 1 wraps to 0
//        MODE_SAT : counter sticks at all-ones
// -----------------------------------------------------------------------------
module perf_counter
    import perf_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = MODE_WRAP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] ONE      = W'(1);
    localparam bit           SAT_MODE = (SAT == MODE_SAT);

    logic         at_max;
    logic [W-1:0] cnt_inc;

    // The all-ones test is done on the W-bit register itself, so the
    // increment never needs a carry-out bit.
    assign at_max  = &cnt;
    assign cnt_inc = cnt + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // Clear discards any increment arriving in the same cycle
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf <= 1'b1;
            end
            // In saturate mode an increment at all-ones only raises ovf
            if (!(SAT_MODE && at_max)) begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule : perf_counter

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
// Bank of NCH event counters plus one cycle counter, each W bits wide, with
// sticky overflow flags, synchronous clear, an atomic snapshot and a
// registered read port.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset, overrides everything
//   en          in   global count enable (clear, snapshot and read ignore it)
//   evt         in   [NCH]       event pulses, bit i-1 drives channel i
//   clr         in   clear all counters and overflow flags (not snapshots)
//   snap_req    in   capture all counters into the snapshot registers
//   snap_valid  out  one-cycle pulse the cycle after a capture
//   rd_sel      in   [SELW]      0 = cycle counter, 1..NCH = event channel
//   rd_src      in   0 = live counter, 1 = snapshot register
//   rd_data     out  [W]         registered read data, one cycle latency
//   ovf         out  [NCH+1]     sticky overflow flags, indexed like rd_sel
//   cnt_bus     out  [(NCH+1)*W] live counters, index k at [k*W +: W]
//
// Parameters:
//   NCH   number of event channels
//   W     counter width
//   SAT   MODE_WRAP or MODE_SAT (see perf_pkg)
//   SELW  width of rd_sel
// -----------------------------------------------------------------------------
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int W    = 8,
    parameter int SAT  = MODE_WRAP,
    parameter int SELW = $clog2(NCH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       evt,
    input  logic                 clr,
    input  logic                 snap_req,
    output logic                 snap_valid,
    input  logic [SELW-1:0]      rd_sel,
    input  logic                 rd_src,
    output logic [W-1:0]         rd_data,
    output logic [NCH:0]         ovf,
    output logic [(NCH+1)*W-1:0] cnt_bus
);

    localparam int NCTR = NCH + 1;

    logic [NCTR-1:0] inc;
    logic [W-1:0]    cnt_arr  [NCTR];
    logic [W-1:0]    snap_arr [NCTR];
    logic [W-1:0]    rd_next;

    // Counter 0 counts every enabled cycle; counter k counts evt[k-1].
    assign inc = {evt, 1'b1} & {NCTR{en}};

    // ---- counters -----------------------------------------------------------
    for (genvar k = 0; k < NCTR; k++) begin : g_ctr
        perf_counter #(
            .W   (W),
            .SAT (SAT)
        ) u_ctr (
            .clk (clk),
            .rst (rst),
            .inc (inc[k]),
            .clr (clr),
            .cnt (cnt_arr[k]),
            .ovf (ovf[k])
        );

        assign cnt_bus[k*W +: W] = cnt_arr[k];
    end

    // ---- snapshot -----------------------------------------------------------
    // Captures the counter registers as they stand before this edge, so a
    // snapshot taken together with clr still holds the pre-clear values.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid <= 1'b0;
            for (int k = 0; k < NCTR; k++) begin
                snap_arr[k] <= '0;
            end
        end else begin
            snap_valid <= snap_req;
            if (snap_req) begin
                for (int k = 0; k < NCTR; k++) begin
                    snap_arr[k] <= cnt_arr[k];
                end
            end
        end
    end

    // ---- read mux -----------------------------------------------------------
    // Out-of-range selects fall through to the zero default.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NCTR; k++) begin
            if (rd_sel == SELW'(k)) begin
                rd_next = (rd_src == SRC_SNAP) ? snap_arr[k] : cnt_arr[k];
            end
        end
    end

    // ---- read register ------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_bank
// Scoreboard bench for perf_counter_bank. Two instances: a wrap-mode bank
// (dut) and a saturate-mode bank (dut_s). Stimulus pushes expected values
// tagged with the cycle they are due; a monitor on the falling edge pops and
// compares. snap_valid pulses are tracked in a separate expected-pulse queue.
// -----------------------------------------------------------------------------
module tb_perf_counter_bank;

    localparam int NCH  = 2;
    localparam int W    = 8;
    localparam int SELW = 2;

    localparam int K_CNT   = 0;
    localparam int K_OVF   = 1;
    localparam int K_RD    = 2;
    localparam int K_SV    = 3;
    localparam int K_S_CNT = 4;
    localparam int K_S_OVF = 5;
    localparam int K_S_RD  = 6;

    typedef struct {
        int    due;
        int    kind;
        int    idx;
        int    exp;
        string name;
    } sb_item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // wrap-mode instance signals
    logic                 rst = 1'b1, en = 1'b0, clr = 1'b0, snap_req = 1'b0, rd_src = 1'b0;
    logic [NCH-1:0]       evt = '0;
    logic [SELW-1:0]      rd_sel = '0;
    logic                 snap_valid;
    logic [W-1:0]         rd_data;
    logic [NCH:0]         ovf;
    logic [(NCH+1)*W-1:0] cnt_bus;

    // saturate-mode instance signals
    logic                 rst_s = 1'b1, en_s = 1'b0, clr_s = 1'b0, snap_req_s = 1'b0, rd_src_s = 1'b0;
    logic [NCH-1:0]       evt_s = '0;
    logic [SELW-1:0]      rd_sel_s = '0;
    logic                 snap_valid_s;
    logic [W-1:0]         rd_data_s;
    logic [NCH:0]         ovf_s;
    logic [(NCH+1)*W-1:0] cnt_bus_s;

    perf_counter_bank #(.NCH(NCH), .W(W), .SAT(0), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr),
        .snap_req(snap_req), .snap_valid(snap_valid),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data),
        .ovf(ovf), .cnt_bus(cnt_bus)
    );

    perf_counter_bank #(.NCH(NCH), .W(W), .SAT(1), .SELW(SELW)) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .evt(evt_s), .clr(clr_s),
        .snap_req(snap_req_s), .snap_valid(snap_valid_s),
        .rd_sel(rd_sel_s), .rd_src(rd_src_s), .rd_data(rd_data_s),
        .ovf(ovf_s), .cnt_bus(cnt_bus_s)
    );

    sb_item_t sb[$];
    int       snap_due[$];
    int       checks = 0;
    int       errors = 0;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect a value in the state that exists right now (after the last edge)
    task automatic expect_now(input int kind, input int idx, input int exp, input string name);
        sb_item_t it;
        it.due  = cyc;
        it.kind = kind;
        it.idx  = idx;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic expect_pulse();
        snap_due.push_back(cyc);
    endtask

    // ---- monitor ------------------------------------------------------------
    always @(negedge clk) begin
        sb_item_t it;
        int       act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                K_CNT:   act = int'(cnt_bus[it.idx*W +: W]);
                K_OVF:   act = int'(ovf);
                K_RD:    act = int'(rd_data);
                K_SV:    act = int'(snap_valid);
                K_S_CNT: act = int'(cnt_bus_s[it.idx*W +: W]);
                K_S_OVF: act = int'(ovf_s);
                K_S_RD:  act = int'(rd_data_s);
                default: act = -1;
            endcase
            checks++;
            if (it.due != cyc || act != it.exp) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d, due %0d)",
                         it.name, act, it.exp, cyc, it.due);
            end
        end
        while (snap_due.size() > 0 && snap_due[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL snap_valid_missing: got no pulse, expected pulse at cycle %0d", snap_due[0]);
            void'(snap_due.pop_front());
        end
        if (snap_valid) begin
            checks++;
            if (snap_due.size() == 0 || snap_due[0] != cyc) begin
                errors++;
                $display("FAIL snap_valid_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                void'(snap_due.pop_front());
            end
        end
        if (snap_valid_s) begin
            checks++;
            errors++;
            $display("FAIL snap_valid_s: got pulse at cycle %0d, expected none", cyc);
        end
    end

    // ---- watchdog -----------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // ---- stimulus -----------------------------------------------------------
    initial begin
        // Reset then count
        tick(5);
        expect_now(K_CNT, 0, 0, "rst_ch0");
        expect_now(K_CNT, 1, 0, "rst_ch1");
        expect_now(K_CNT, 2, 0, "rst_ch2");
        expect_now(K_OVF, 0, 0, "rst_ovf");
        expect_now(K_RD,  0, 0, "rst_rd");
        expect_now(K_SV,  0, 0, "rst_snap_valid");

        rst = 1'b0; en = 1'b1; evt = 2'b01; rd_sel = 2'd1; rd_src = 1'b0;
        tick(10);
        expect_now(K_CNT, 0, 10, "count_ch0");
        expect_now(K_CNT, 1, 10, "count_ch1");
        expect_now(K_CNT, 2, 0,  "count_ch2");
        expect_now(K_OVF, 0, 0,  "count_ovf");
        expect_now(K_RD,  0, 9,  "count_rd_pre_edge");
        en = 1'b0; evt = 2'b00;
        tick();
        expect_now(K_RD,  0, 10, "count_rd_ch1");
        expect_now(K_CNT, 0, 10, "en0_hold_ch0");

        // Enable low with events present, then out-of-range select
        evt = 2'b11;
        tick(8);
        expect_now(K_CNT, 0, 10, "en0_ch0");
        expect_now(K_CNT, 1, 10, "en0_ch1");
        expect_now(K_CNT, 2, 0,  "en0_ch2");
        rd_sel = 2'd3; rd_src = 1'b0;
        tick();
        expect_now(K_RD, 0, 0, "rd_sel3_live");
        rd_src = 1'b1;
        tick();
        expect_now(K_RD, 0, 0, "rd_sel3_snap");

        // Snapshot versus live
        en = 1'b1; evt = 2'b00; rd_sel = 2'd0; rd_src = 1'b0;
        tick(10);
        expect_now(K_CNT, 0, 20, "pre_snap_ch0");
        snap_req = 1'b1;
        tick();
        expect_pulse();
        snap_req = 1'b0; rd_src = 1'b1;
        tick();
        expect_now(K_SV,  0, 0,  "snap_valid_one_cycle");
        expect_now(K_RD,  0, 20, "snap_rd_ch0");
        expect_now(K_CNT, 0, 22, "live_ch0_22");
        rd_src = 1'b0;
        tick();
        expect_now(K_RD, 0, 22, "live_rd_22");
        tick();
        expect_now(K_RD, 0, 23, "live_rd_23");

        // Back-to-back snapshots (ch0 is 24 here)
        snap_req = 1'b1;
        tick();
        expect_pulse();
        tick();
        expect_pulse();
        snap_req = 1'b0; rd_src = 1'b1;
        tick();
        expect_now(K_RD,  0, 25, "b2b_snap_rd");
        expect_now(K_CNT, 0, 27, "b2b_live_ch0");

        // Clear together with snapshot at ch0 = 50
        rd_src = 1'b0;
        tick(23);
        expect_now(K_CNT, 0, 50, "pre_clr_ch0");
        clr = 1'b1; snap_req = 1'b1;
        tick();
        expect_pulse();
        expect_now(K_CNT, 0, 0, "clr_ch0");
        expect_now(K_CNT, 1, 0, "clr_ch1");
        clr = 1'b0; snap_req = 1'b0; rd_src = 1'b1; rd_sel = 2'd0;
        tick();
        expect_now(K_RD,  0, 50, "clr_snap_rd_ch0");
        expect_now(K_CNT, 0, 1,  "post_clr_ch0");
        rd_sel = 2'd1;
        tick();
        expect_now(K_RD,  0, 10, "clr_snap_rd_ch1");

        // Mid-count reset
        rst = 1'b1; evt = 2'b11;
        tick();
        expect_now(K_CNT, 0, 0, "midrst_ch0");
        expect_now(K_RD,  0, 0, "midrst_rd");
        expect_now(K_OVF, 0, 0, "midrst_ovf");

        // Wrap: 260 enabled cycles on the cycle counter
        rst = 1'b0; evt = 2'b00; rd_src = 1'b0; rd_sel = 2'd0;
        tick(255);
        expect_now(K_CNT, 0, 255, "wrap_ch0_255");
        expect_now(K_OVF, 0, 0,   "wrap_ovf_before");
        tick();
        expect_now(K_CNT, 0, 0,   "wrap_ch0_0");
        expect_now(K_OVF, 0, 1,   "wrap_ovf_set");
        expect_now(K_RD,  0, 255, "wrap_rd_255");
        tick(4);
        expect_now(K_CNT, 0, 4, "wrap_ch0_4");
        tick(10);
        expect_now(K_CNT, 0, 14, "wrap_ch0_14");
        expect_now(K_OVF, 0, 1,  "wrap_ovf_sticky");
        clr = 1'b1;
        tick();
        expect_now(K_OVF, 0, 0, "wrap_ovf_clr");
        expect_now(K_CNT, 0, 0, "wrap_ch0_clr");
        clr = 1'b0;

        // Saturate instance
        expect_now(K_S_CNT, 2, 0, "sat_rst_ch2");
        expect_now(K_S_OVF, 0, 0, "sat_rst_ovf");
        rst_s = 1'b0; en_s = 1'b1; evt_s = 2'b10; rd_sel_s = 2'd2;
        tick(255);
        expect_now(K_S_CNT, 2, 255, "sat_ch2_255");
        expect_now(K_S_OVF, 0, 0,   "sat_ovf_at_max");
        tick();
        expect_now(K_S_CNT, 2, 255, "sat_ch2_hold");
        expect_now(K_S_OVF, 0, 5,   "sat_ovf_set");
        tick(44);
        expect_now(K_S_CNT, 2, 255, "sat_ch2_300");
        expect_now(K_S_CNT, 0, 255, "sat_ch0_300");
        expect_now(K_S_CNT, 1, 0,   "sat_ch1_300");
        expect_now(K_S_RD,  0, 255, "sat_rd_ch2");
        clr_s = 1'b1;
        tick();
        expect_now(K_S_CNT, 2, 0, "sat_ch2_clr");
        expect_now(K_S_OVF, 0, 0, "sat_ovf_clr");
        clr_s = 1'b0; en_s = 1'b0;

        // Drain and confirm nothing left unchecked
        tick(3);
        checks++;
        if (sb.size() != 0 || snap_due.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d items and %0d pulses pending, expected 0 and 0",
                     sb.size(), snap_due.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_perf_counter_bank

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of event counters for CPU/cache performance measurement.
- Generalises the fixed 8-bit clk/inst/hit counters in the processor top to NCH event channels plus one cycle counter, each W bits wide.
- Adds wrap/saturate mode, sticky overflow flags, synchronous clear, an atomic snapshot handshake and a registered read port.
- Instantiated in the top level; fed by single-cycle event pulses from the pipeline and cache (instruction retired, cache hit, ...).

Parameters:
- NCH, 2, number of event channels (channel 1 = instructions, channel 2 = hits in the default configuration).
- W, 8, counter width in bits.
- SAT, 0, overflow mode: 0 = wrap to zero, 1 = saturate at all-ones.
- SELW, $clog2(NCH+1), width of the read select.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global count enable.
- evt  in  NCH  per-channel event pulse; bit i-1 drives channel i.
- clr  in  1  synchronous clear of counters and overflow flags.
- snap_req  in  1  single-cycle request to capture all counters.
- snap_valid  out  1  one-cycle pulse: snapshot registers updated.
- rd_sel  in  SELW  0 = cycle counter, 1..NCH = event channel.
- rd_src  in  1  0 = read live counter, 1 = read snapshot register.
- rd_data  out  W  registered read data.
- ovf  out  NCH+1  sticky overflow flags, indexed like rd_sel.
- cnt_bus  out  (NCH+1)*W  live counters, index k at bits [k*W +: W].

Behaviour:
- Reset (rst=1 at an edge) clears all counters, snapshot registers, ovf, snap_valid and rd_data to 0. rst overrides every other input.
- Counter k=0 increments by 1 on each edge with en=1.
- Counter k≥1 increments by 1 on each edge with en=1 and evt[k-1]=1.
- All counters update in the same cycle. There are no cross-channel dependencies.
- en=0: all counters hold. clr, snapshot and read still operate.
- Wrap mode (SAT=0): all-ones+1 becomes 0, and ovf[k] is set.
- Saturate mode (SAT=1): the counter holds at all-ones, and ovf[k] is set on any increment attempted at all-ones.
- ovf[k] stays set until clr or rst.
- clr=1 at an edge: all counters and ovf go to 0. Any increment in that cycle is discarded, because clr has priority over counting. Snapshot registers are not affected by clr.
- snap_req=1 at an edge:
  - All NCH+1 snapshot registers capture the current counter register values, i.e. pre-increment and pre-clear.
  - snap_valid is 1 for exactly the following cycle.
  - Back-to-back requests are allowed; each one produces its own pulse.
- snap_req with clr in the same cycle: the snapshot holds the pre-clear values, and the counters clear.
- Read port:
  - Latency is 1 cycle: rd_data at cycle t+1 reflects rd_sel and rd_src sampled at edge t.
  - For live reads it returns the counter value before the update at that edge.
  - rd_sel > NCH returns 0.
- cnt_bus is purely the counter registers, with no extra latency.
- No arithmetic wider than W+1 bits is needed. The comparison to all-ones uses the W-bit register.

Decomposition:
- Shared package perf_pkg holds:
  - localparams for the channel indices (CH_CYCLE=0, CH_INST=1, CH_HIT=2);
  - the mode encodings (MODE_WRAP=0, MODE_SAT=1).
- One natural sub-module: perf_counter. It is a single W-bit counter with inc, clr and SAT parameter, and outputs cnt and ovf. It is instantiated NCH+1 times via generate.
- The snapshot, read mux and snap_valid logic live in perf_counter_bank.

Test Plan:
- Reset then count: rst high 5 cycles, then en=1 and evt=2'b01 for 10 cycles. Expect cnt_bus channel0=10, channel1=10, channel2=0, ovf=0, and rd_sel=1 with rd_src=0 giving rd_data=10 one cycle later.
- Wrap: W=8, SAT=0, en=1 for 260 cycles. Expect channel0=4 and ovf[0]=1. ovf[0] stays 1 after a further 10 cycles and clears to 0 on the edge after clr=1.
- Saturate: SAT=1, evt[1]=1 for 300 cycles. Expect channel2=255, ovf[2]=1, and it holds 255 with evt still asserted.
- Snapshot versus live: at channel0=20 pulse snap_req. Expect snap_valid high exactly one cycle later. Then rd_src=1, rd_sel=0 gives rd_data=20, while the live read continues 22, 23, ...
- Clear with snapshot: with channel0=50, assert clr and snap_req in the same cycle. Expect the snapshot to read 50 and the live counter to read 0 the next cycle, with that cycle's increment discarded.
- Enable and out-of-range select: en=0 with evt=2'b11 for 8 cycles leaves all counters unchanged. rd_sel=3 (NCH=2) returns rd_data=0. rst asserted mid-count zeroes all outputs on the next edge.
